// File: rtl/si5340_cfg_sequencer.sv
// Si5340 power-up configuration sequencer: walks the config ROM and emits
// paged I2C register writes on a one-byte-outstanding command interface.
module si5340_cfg_sequencer #(
  parameter int unsigned WORD_NUMBER  = 326,
  parameter int unsigned MEM_WIDTH    = 24,
  parameter logic [6:0]  SLAVE_ADDR   = 7'h74,
  parameter int unsigned DELAY_INDEX  = 2,
  parameter int unsigned DELAY_CYCLES = 37_500_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           start_i,
  output logic [$clog2(WORD_NUMBER)-1:0] rom_addr_o,
  input  logic [MEM_WIDTH-1:0]           rom_data_i,
  output logic                           cmd_valid_o,
  input  logic                           cmd_ready_i,
  output logic [7:0]                     cmd_data_o,
  output logic                           cmd_start_o,
  output logic                           cmd_stop_o,
  input  logic                           rsp_valid_i,
  input  logic                           rsp_nack_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o,
  output logic [$clog2(WORD_NUMBER)-1:0] fail_index_o
);

  localparam int unsigned AW = $clog2(WORD_NUMBER);
  localparam int unsigned CW = (DELAY_CYCLES < 2) ? 1 : $clog2(DELAY_CYCLES + 1);
  localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [AW-1:0] LAST_IDX  = AW'(WORD_NUMBER - 1);
  localparam logic [AW-1:0] PAUSE_IDX = AW'(DELAY_INDEX);
  localparam logic [CW-1:0] PAUSE_LEN = CW'(DELAY_CYCLES);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [7:0]    ADDR_WR   = {SLAVE_ADDR, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_PAGE, S_WRITE,
    S_WAIT_RSP, S_PAUSE, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t               r_state;
  logic [AW-1:0]        r_index;
  logic [MEM_WIDTH-1:0] r_word;
  logic [7:0]           r_page;
  logic                 r_page_valid;
  logic                 r_txn_page;
  logic [1:0]           r_byte;
  logic [RW-1:0]        r_retry;
  logic [CW-1:0]        r_pause;

  logic [7:0] w_byte_data;
  logic       w_is_page;

  always_comb begin
    w_is_page   = (r_state == S_PAGE);
    w_byte_data = ADDR_WR;
    unique case (r_byte)
      2'd0:    w_byte_data = ADDR_WR;
      2'd1:    w_byte_data = w_is_page ? 8'h01 : r_word[15:8];
      default: w_byte_data = w_is_page ? r_word[23:16] : r_word[7:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_word       <= '0;
      r_page       <= '0;
      r_page_valid <= 1'b0;
      r_txn_page   <= 1'b0;
      r_byte       <= '0;
      r_retry      <= '0;
      r_pause      <= '0;
      rom_addr_o   <= '0;
      cmd_valid_o  <= 1'b0;
      cmd_data_o   <= '0;
      cmd_start_o  <= 1'b0;
      cmd_stop_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      fail_index_o <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            r_index      <= '0;
            rom_addr_o   <= '0;
            r_page_valid <= 1'b0;
            r_retry      <= '0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            busy_o       <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          // Page decision uses the ROM word directly; r_word is loaded in the same edge.
          r_word <= rom_data_i;
          r_byte <= '0;
          if (!r_page_valid || (rom_data_i[23:16] != r_page)) begin
            r_txn_page <= 1'b1;
            r_state    <= S_PAGE;
          end else begin
            r_txn_page <= 1'b0;
            r_state    <= S_WRITE;
          end
        end
        S_PAGE, S_WRITE: begin
          if (!cmd_valid_o) begin
            cmd_valid_o <= 1'b1;
            cmd_data_o  <= w_byte_data;
            cmd_start_o <= (r_byte == 2'd0);
            cmd_stop_o  <= (r_byte == 2'd2);
          end else if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            cmd_start_o <= 1'b0;
            cmd_stop_o  <= 1'b0;
            r_state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid_i) begin
            if (rsp_nack_i) begin
              if (r_retry == RETRY_LIM) begin
                busy_o       <= 1'b0;
                error_o      <= 1'b1;
                fail_index_o <= r_index;
                r_state      <= S_ERROR;
              end else begin
                r_retry <= r_retry + RW'(1);
                r_byte  <= '0;
                if (r_txn_page) begin
                  r_page_valid <= 1'b0;
                  r_state      <= S_PAGE;
                end else begin
                  r_state <= S_WRITE;
                end
              end
            end else if (r_byte == 2'd2) begin
              r_byte <= '0;
              if (r_txn_page) begin
                r_page       <= r_word[23:16];
                r_page_valid <= 1'b1;
                r_txn_page   <= 1'b0;
                r_state      <= S_WRITE;
              end else if (r_index == PAUSE_IDX) begin
                r_pause <= PAUSE_LEN;
                r_state <= S_PAUSE;
              end else begin
                r_state <= S_NEXT;
              end
            end else begin
              r_byte  <= r_byte + 2'd1;
              r_state <= r_txn_page ? S_PAGE : S_WRITE;
            end
          end
        end
        S_PAUSE: begin
          if (r_pause <= CW'(1)) r_state <= S_NEXT;
          else                   r_pause <= r_pause - CW'(1);
        end
        S_NEXT: begin
          if (r_index == LAST_IDX) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_index    <= r_index + AW'(1);
            rom_addr_o <= r_index + AW'(1);
            r_retry    <= '0;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Bench for si5340_cfg_sequencer: synchronous ROM and byte-engine models,
// expected byte stream and inter-byte timing from a transaction-level model.
module tb_si5340_cfg_sequencer;

  localparam int unsigned WN = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DI = 1;
  localparam int unsigned DC = 10;
  localparam int unsigned MR = 3;
  localparam int unsigned BUDGET = 3000;

  logic          clk_i = 1'b0;
  logic          arstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] rom_addr_o;
  logic [23:0]   rom_data_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i = 1'b0;
  logic [7:0]    cmd_data_o;
  logic          cmd_start_o;
  logic          cmd_stop_o;
  logic          rsp_valid_i = 1'b0;
  logic          rsp_nack_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [AW-1:0] fail_index_o;

  si5340_cfg_sequencer #(
    .WORD_NUMBER (WN),
    .MEM_WIDTH   (24),
    .SLAVE_ADDR  (7'h74),
    .DELAY_INDEX (DI),
    .DELAY_CYCLES(DC),
    .MAX_RETRY   (MR)
  ) dut (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .start_i     (start_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_data_o  (cmd_data_o),
    .cmd_start_o (cmd_start_o),
    .cmd_stop_o  (cmd_stop_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_nack_i  (rsp_nack_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .fail_index_o(fail_index_o)
  );

  always #5 clk_i = ~clk_i;

  logic [23:0] rom [WN];
  always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        s;
    logic        p;
    int unsigned gap;
  } byte_t;

  byte_t got_q[$];
  byte_t exp_q[$];

  logic [127:0] nmask = '0;
  bit           rdy_rand = 1'b0;
  int unsigned  stall = 0;
  int unsigned  bytes_acc = 0;
  int unsigned  event_cyc = 0;
  bit           hs = 1'b0;

  // Monitor: handshake logging, hold-while-stalled and start/stop qualification.
  initial begin
    bit          prev_v, prev_r, prev_s, prev_p;
    logic [7:0]  prev_d;
    int unsigned cur_gap;
    prev_v = 0; prev_r = 0; prev_s = 0; prev_p = 0; prev_d = '0; cur_gap = 0;
    forever begin
      @(negedge clk_i);
      if (!arstn_i) begin
        hs = 0;
        prev_v = 0;
      end else begin
        if (prev_v && !prev_r)
          check("hold", {cmd_valid_o, cmd_start_o, cmd_stop_o, cmd_data_o},
                {1'b1, prev_s, prev_p, prev_d});
        if (!cmd_valid_o)
          check("start_stop_idle", {cmd_start_o, cmd_stop_o}, 2'b00);
        if (cmd_valid_o && !prev_v) cur_gap = cyc - event_cyc;
        hs = cmd_valid_o && cmd_ready_i;
        if (hs) got_q.push_back('{cmd_data_o, cmd_start_o, cmd_stop_o, cur_gap});
        if (rsp_valid_i) event_cyc = cyc;
        prev_v = cmd_valid_o;
        prev_r = cmd_ready_i;
        prev_s = cmd_start_o;
        prev_p = cmd_stop_o;
        prev_d = cmd_data_o;
      end
    end
  end

  // Byte engine: random ready, random response latency, NACK chosen per accepted byte.
  initial begin
    bit          pend, nack_now;
    int unsigned dly;
    pend = 0; nack_now = 0; dly = 0;
    forever begin
      @(posedge clk_i);
      #1;
      rsp_valid_i = 1'b0;
      rsp_nack_i  = 1'b0;
      if (!arstn_i) begin
        pend = 0;
        cmd_ready_i = 1'b0;
      end else begin
        if (hs) begin
          pend = 1;
          dly = $urandom_range(0, 3);
          nack_now = (bytes_acc < 128) ? nmask[bytes_acc] : 1'b0;
          bytes_acc++;
        end
        if (pend) begin
          if (dly == 0) begin
            rsp_valid_i = 1'b1;
            rsp_nack_i  = nack_now;
            pend = 0;
          end else begin
            dly--;
          end
        end
        if (stall > 0) begin
          cmd_ready_i = 1'b0;
          stall--;
        end else begin
          cmd_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    end
  end

  // Transaction-level reference: per entry, page write on page change, then
  // register write; any NACK restarts that transaction until retries run out.
  // Gap = cycles from the triggering event (start pulse / response) to valid.
  task automatic model(output bit m_err, output int unsigned m_fidx);
    int unsigned n, tries, g;
    bit          pv, pgtx, nk, fin;
    logic [7:0]  pg;
    logic [23:0] w;
    logic [7:0]  b [3];
    exp_q.delete();
    n = 0; pv = 0; pg = '0; m_err = 0; m_fidx = 0;
    for (int e = 0; e < int'(WN) && !m_err; e++) begin
      w = rom[e];
      tries = 0;
      fin = 0;
      if (e == 0)                g = 4;
      else if (e - 1 == int'(DI)) g = 5 + DC;
      else                       g = 5;
      while (!fin && !m_err) begin
        pgtx = !pv || (w[23:16] != pg);
        b[0] = 8'hE8;
        b[1] = pgtx ? 8'h01 : w[15:8];
        b[2] = pgtx ? w[23:16] : w[7:0];
        nk = 0;
        for (int k = 0; k < 3 && !nk; k++) begin
          exp_q.push_back('{b[k], k == 0, k == 2, g});
          g = 2;
          nk = (n < 128) ? nmask[n] : 1'b0;
          n++;
        end
        if (nk) begin
          if (tries == MR) begin
            m_err = 1;
            m_fidx = e;
          end else begin
            tries++;
            if (pgtx) pv = 0;
          end
        end else if (pgtx) begin
          pv = 1;
          pg = w[23:16];
        end else begin
          fin = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_pass(input bit rr, input int unsigned st);
    got_q.delete();
    bytes_acc = 0;
    rdy_rand = rr;
    stall = st;
    start_i = 1'b1;
    event_cyc = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_end(input bit mid_start);
    int unsigned k;
    k = 0;
    while (!(done_o || error_o) && k < BUDGET) begin
      tick();
      k++;
      if (mid_start && k == 20) begin
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k++;
      end
    end
    check("pass_end_timeout", 32'(k < BUDGET), 32'd1);
  endtask

  task automatic compare(input string nm, input bit use_exp, input bit edone,
                         input bit eerr, input int unsigned efidx, input int unsigned en);
    bit          m_err;
    int unsigned m_fidx, lim;
    model(m_err, m_fidx);
    if (use_exp) check({nm, "_nbytes_tbl"}, got_q.size(), en);
    check({nm, "_nbytes"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int unsigned i = 0; i < lim; i++)
      check($sformatf("%s_byte%0d{d,s,p,gap}", nm, i),
            {got_q[i].d, got_q[i].s, got_q[i].p, 6'd0, got_q[i].gap[15:0]},
            {exp_q[i].d, exp_q[i].s, exp_q[i].p, 6'd0, exp_q[i].gap[15:0]});
    if (!use_exp) begin
      edone = !m_err;
      eerr  = m_err;
      efidx = m_fidx;
    end
    check({nm, "_done"}, 32'(done_o), 32'(edone));
    check({nm, "_error"}, 32'(error_o), 32'(eerr));
    check({nm, "_busy"}, 32'(busy_o), 32'd0);
    if (eerr) check({nm, "_fail_index"}, 32'(fail_index_o), efidx);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_cmd"}, {cmd_valid_o, cmd_start_o, cmd_stop_o, cmd_data_o}, '0);
    check({nm, "_rom_addr"}, 32'(rom_addr_o), 32'd0);
    check({nm, "_status"}, {busy_o, done_o, error_o}, 3'b000);
    check({nm, "_fail_index"}, 32'(fail_index_o), 32'd0);
  endtask

  task automatic load_base();
    rom[0] = 24'h000B24;
    rom[1] = 24'h000B25;
    rom[2] = 24'h0A0312;
    rom[3] = 24'h0A0400;
  endtask

  typedef struct {
    string        name;
    logic [127:0] nm;
    bit           rr;
    int unsigned  st;
    bit           mid;
    bit           edone;
    bit           eerr;
    int unsigned  efidx;
    int unsigned  en;
  } vec_t;

  vec_t vecs [6];
  int unsigned wc;

  initial begin
    vecs[0] = '{"ack_all",     '0,               1'b0, 0,  1'b0, 1'b1, 1'b0, 0, 18};
    vecs[1] = '{"page_nack",   128'h1 << 10,     1'b1, 0,  1'b0, 1'b1, 1'b0, 0, 20};
    vecs[2] = '{"retry_exh",   128'hF << 6,      1'b1, 0,  1'b0, 1'b0, 1'b1, 1, 10};
    vecs[3] = '{"write_nack2", 128'h3 << 15,     1'b1, 0,  1'b0, 1'b1, 1'b0, 0, 20};
    vecs[4] = '{"ready_stall", '0,               1'b0, 30, 1'b0, 1'b1, 1'b0, 0, 18};
    vecs[5] = '{"start_busy",  '0,               1'b1, 0,  1'b1, 1'b1, 1'b0, 0, 18};

    load_base();
    repeat (3) tick();
    check_reset_vals("reset");
    arstn_i = 1'b1;
    repeat (2) tick();
    check_reset_vals("post_reset_idle");

    for (int unsigned v = 0; v < 6; v++) begin
      nmask = vecs[v].nm;
      start_pass(vecs[v].rr, vecs[v].st);
      check({vecs[v].name, "_busy_after_start"}, 32'({busy_o, done_o, error_o}), 32'b100);
      wait_end(vecs[v].mid);
      compare(vecs[v].name, 1'b1, vecs[v].edone, vecs[v].eerr, vecs[v].efidx, vecs[v].en);
      repeat (3) tick();
    end

    // Reset while pausing after the preamble, then a clean restart from entry 0.
    nmask = '0;
    start_pass(1'b0, 0);
    wc = 0;
    while (got_q.size() < 9 && wc < BUDGET) begin
      tick();
      wc++;
    end
    check("pause_reach_timeout", 32'(wc < BUDGET), 32'd1);
    repeat (7) tick();
    check("in_pause_quiet", {busy_o, cmd_valid_o}, 2'b10);
    arstn_i = 1'b0;
    #1;
    check_reset_vals("reset_in_pause");
    repeat (3) tick();
    arstn_i = 1'b1;
    tick();
    start_pass(1'b1, 0);
    wait_end(1'b0);
    compare("after_reset", 1'b1, 1'b1, 1'b0, 0, 18);

    // Start from DONE clears done immediately and launches a new pass.
    start_pass(1'b0, 0);
    check("restart_from_done", {busy_o, done_o, error_o}, 3'b100);
    wait_end(1'b0);
    compare("restart_pass", 1'b1, 1'b1, 1'b0, 0, 18);

    for (int unsigned r = 0; r < 6; r++) begin
      for (int e = 0; e < int'(WN); e++)
        rom[e] = {7'd0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom)};
      for (int i = 0; i < 128; i++) nmask[i] = ($urandom_range(0, 7) == 0);
      start_pass(1'b1, 0);
      wait_end(1'b0);
      compare($sformatf("rand%0d", r), 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
